seq_pattern_detector: RTL and testbench
=======================================

# seq_pattern_detector

Parametrised serial pattern detector for the single-bit input stream path. It replaces the fixed-sequence detector FSM with a runtime-loadable PAT_W-bit pattern, overlapping and non-overlapping match modes, a qualifying enable, and a saturating match counter. The Mealy match pulse `z` keeps the existing single-cycle semantics, so downstream logic is unchanged.

## Interface
Parameters:
- PAT_W, 4, pattern length in bits; legal range 2..16.
- CNT_W, 8, width of the match counter; legal range 1..16.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  bit-valid qualifier; `y` is consumed only in cycles where en=1.
- y  in  1  serial data bit.
- load  in  1  loads the pattern from `pat_in` and restarts detection.
- pat_in  in  PAT_W  pattern to load; MSB is the first (oldest) bit of the sequence.
- overlap  in  1  1 = overlapping matches allowed; 0 = history cleared after each match. Sampled every cycle.
- z  out  1  Mealy match pulse, combinational from state, `y`, `en` and `load`.
- match_cnt  out  CNT_W  number of matches since the last load or reset; saturates.
- cnt_sat  out  1  high while match_cnt equals all-ones.
- state  out  2  FSM state: IDLE=2'b00, FILL=2'b01, ARMED=2'b11. 2'b10 is illegal and recovers to IDLE.

## Operation
- Registers:
  - pattern `pat[PAT_W-1:0]`
  - history `h[PAT_W-2:0]`, newest bit in the LSB
  - fill count `f` (0..PAT_W-1)
  - `match_cnt`
  - FSM state
- Reset, while rst=0:
  - state=IDLE, pat=0, h=0, f=0, match_cnt=0.
  - Therefore cnt_sat=0 (or 1 when CNT_W counts to zero, which never occurs since CNT_W≥1) and z=0.
- IDLE:
  - en and y are ignored; z=0.
  - load=1 → pat<=pat_in, h<=0, f<=0, match_cnt<=0, next state FILL.
- load in FILL or ARMED:
  - Same effect as in IDLE.
  - load has priority over en; y is discarded that cycle and z=0.
- FILL (f < PAT_W-1), when en=1 and load=0:
  - h<={h[PAT_W-3:0],y}. For PAT_W=2 this is h<=y.
  - f<=f+1.
  - Go to ARMED when f+1 == PAT_W-1.
  - z=0 always in FILL.
- ARMED (f == PAT_W-1):
  - Candidate word is {h,y}. match = en & ~load & ({h,y}==pat). z=match.
  - match with overlap=1: shift as in FILL, stay ARMED.
  - match with overlap=0: h<=0, f<=0, go to FILL.
  - no match with en=1: shift, stay ARMED.
- en=0 in any state: h, f, state and match_cnt hold; z=0.
- Counter:
  - On a match, match_cnt<=match_cnt+1 unless it is all-ones; it never wraps.
  - cnt_sat = &match_cnt.
- Illegal state 2'b10: next state IDLE and z=0. Pattern is kept, but a new load is required.

## Timing
- Match latency:
  - z rises combinationally in the same cycle as the final pattern bit on y with en=1.
  - match_cnt reflects that match after the next rising edge.
- First possible match: the PAT_W-th valid bit after a load. The prior PAT_W-1 bits only fill the history.
- Non-overlap mode: after a match, the next match needs PAT_W further valid bits.
- Reset is asynchronous:
  - Asserting rst mid-stream clears all outputs immediately, without waiting for a clock.
  - Deassertion is synchronised externally. The first edge after deassertion behaves as IDLE.
- Switching overlap mid-stream: takes effect on the next match; no other side effects.
- z is glitch-free only with respect to the clock; consumers sample it on clk.

## Test plan
1. Reset, then en=1, y=1 for 5 cycles without a load → state=00, z=0, match_cnt=0 throughout. Pulse rst low mid-stream after matches → match_cnt=0 and z=0 immediately.
2. PAT_W=4, load pat 1010, overlap=1, stream 1,0,1,0,1,0 with en=1 → z=1 on bits 4 and 6 only; final match_cnt=2; state=11.
3. Same stream with overlap=0 → z=1 on bit 4 only; state=01 after bit 4; match_cnt=1.
4. Load 1011, stream 1,0,(en=0,y=1 for 3 cycles),1,1 → z=1 only on the final bit; held cycles change neither z nor h/f.
5. CNT_W=2, pattern 1111, overlap=1, seven 1s → z=1 on bits 4–7; match_cnt=3 with cnt_sat=1 after the 3rd match, still 3 after the 4th.
6. In ARMED with {h,y}==pat, assert load=1 and en=1 together with pat_in=0110 → z=0, match_cnt=0, state=01, pat=0110.

Source files
------------

// File: rtl/seq_pattern_detector.sv
// Serial pattern detector with a runtime-loadable pattern, overlap/non-overlap
// matching, a bit-valid qualifier and a saturating match counter.
module seq_pattern_detector #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             y,
    input  logic             load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             overlap,
    output logic             z,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat,
    output logic [1:0]       state
);

    localparam int FW = $clog2(PAT_W);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FILL  = 2'b01,
        ST_ARMED = 2'b11
    } state_t;

    state_t             state_q, state_d;
    logic [PAT_W-1:0]   pat_q, pat_d;
    logic [PAT_W-2:0]   h_q, h_d;
    logic [FW-1:0]      f_q, f_d;
    logic [CNT_W-1:0]   match_cnt_q, match_cnt_d;

    logic [PAT_W-1:0]   cand_s;
    logic [PAT_W-2:0]   h_shift_s;
    logic               match_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + CNT_W'(1);
        end
    endfunction

    // Candidate word and its low bits, which double as the shifted history.
    always_comb begin
        cand_s    = {h_q, y};
        h_shift_s = cand_s[PAT_W-2:0];
        match_s   = (state_q == ST_ARMED) && en && !load && (cand_s == pat_q);
    end

    // Next-state logic; load wins over en in every legal state.
    always_comb begin
        state_d     = state_q;
        pat_d       = pat_q;
        h_d         = h_q;
        f_d         = f_q;
        match_cnt_d = match_cnt_q;
        case (state_q)
            ST_IDLE, ST_FILL, ST_ARMED: begin
                if (load) begin
                    pat_d       = pat_in;
                    h_d         = '0;
                    f_d         = '0;
                    match_cnt_d = '0;
                    state_d     = ST_FILL;
                end else if (en && (state_q == ST_FILL)) begin
                    h_d = h_shift_s;
                    f_d = f_q + FW'(1);
                    if (f_q == FW'(PAT_W - 2)) begin
                        state_d = ST_ARMED;
                    end else begin
                        state_d = ST_FILL;
                    end
                end else if (en && (state_q == ST_ARMED)) begin
                    if (match_s) begin
                        match_cnt_d = sat_inc(match_cnt_q);
                    end else begin
                        match_cnt_d = match_cnt_q;
                    end
                    if (match_s && !overlap) begin
                        h_d     = '0;
                        f_d     = '0;
                        state_d = ST_FILL;
                    end else begin
                        h_d     = h_shift_s;
                        state_d = ST_ARMED;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            // 2'b10 is unreachable; fall back to IDLE and wait for a load.
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            pat_q       <= '0;
            h_q         <= '0;
            f_q         <= '0;
            match_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pat_q       <= pat_d;
            h_q         <= h_d;
            f_q         <= f_d;
            match_cnt_q <= match_cnt_d;
        end
    end

    assign z         = match_s;
    assign match_cnt = match_cnt_q;
    assign cnt_sat   = &match_cnt_q;
    assign state     = state_q;

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Directed bench for seq_pattern_detector: a CNT_W=8 and a CNT_W=2 instance
// share one stimulus stream; expectations are hand-computed per scenario.
module tb_seq_pattern_detector;

    logic       clk;
    logic       rst;
    logic       en;
    logic       y;
    logic       load;
    logic [3:0] pat_in;
    logic       overlap;

    logic       z_a, z_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;
    logic       sat_a, sat_b;
    logic [1:0] st_a, st_b;

    int total;
    int bad;

    seq_pattern_detector #(.PAT_W(4), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .en(en), .y(y), .load(load), .pat_in(pat_in),
        .overlap(overlap), .z(z_a), .match_cnt(cnt_a), .cnt_sat(sat_a), .state(st_a)
    );

    seq_pattern_detector #(.PAT_W(4), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .en(en), .y(y), .load(load), .pat_in(pat_in),
        .overlap(overlap), .z(z_b), .match_cnt(cnt_b), .cnt_sat(sat_b), .state(st_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one bit, sample z mid-cycle, then advance past the rising edge.
    task automatic send(input logic e, input logic b, output logic zo);
        en   = e;
        y    = b;
        load = 1'b0;
        @(negedge clk);
        zo = z_a;
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [3:0] p);
        en     = 1'b0;
        load   = 1'b1;
        pat_in = p;
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    task automatic test_reset;
        logic zo;
        rst = 1'b0; en = 1'b0; y = 1'b0; load = 1'b0; pat_in = 4'b0000; overlap = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (st_a !== 2'b00 || cnt_a !== 8'd0 || z_a !== 1'b0 || sat_a !== 1'b0) begin
            $display("FAIL reset_state: state=%b cnt=%0d z=%b sat=%b, want 00/0/0/0", st_a, cnt_a, z_a, sat_a);
            bad++;
        end
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send(1'b1, 1'b1, zo);
            total++;
            if (zo !== 1'b0 || st_a !== 2'b00 || cnt_a !== 8'd0) begin
                $display("FAIL idle_ignore[%0d]: z=%b state=%b cnt=%0d, want 0/00/0", i, zo, st_a, cnt_a);
                bad++;
            end
        end
    endtask

    task automatic test_overlap;
        logic       zo;
        logic [5:0] bits;
        logic [5:0] exp_z;
        bits  = 6'b101010;
        exp_z = 6'b000101;
        overlap = 1'b1;
        do_load(4'b1010);
        for (int i = 0; i < 6; i++) begin
            send(1'b1, bits[5-i], zo);
            total++;
            if (zo !== exp_z[5-i]) begin
                $display("FAIL overlap_z[bit%0d]: got %b want %b", i + 1, zo, exp_z[5-i]);
                bad++;
            end
        end
        total++;
        if (cnt_a !== 8'd2 || st_a !== 2'b11) begin
            $display("FAIL overlap_end: cnt=%0d state=%b, want 2/11", cnt_a, st_a);
            bad++;
        end
    endtask

    task automatic test_async_reset;
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        total++;
        if (cnt_a !== 8'd0 || z_a !== 1'b0 || st_a !== 2'b00) begin
            $display("FAIL async_reset: cnt=%0d z=%b state=%b, want 0/0/00", cnt_a, z_a, st_a);
            bad++;
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_nonoverlap;
        logic       zo;
        logic [5:0] bits;
        logic [5:0] exp_z;
        bits  = 6'b101010;
        exp_z = 6'b000100;
        overlap = 1'b0;
        do_load(4'b1010);
        total++;
        if (cnt_a !== 8'd0 || st_a !== 2'b01) begin
            $display("FAIL load_state: cnt=%0d state=%b, want 0/01", cnt_a, st_a);
            bad++;
        end
        for (int i = 0; i < 6; i++) begin
            send(1'b1, bits[5-i], zo);
            total++;
            if (zo !== exp_z[5-i]) begin
                $display("FAIL nonoverlap_z[bit%0d]: got %b want %b", i + 1, zo, exp_z[5-i]);
                bad++;
            end
            if (i == 3) begin
                total++;
                if (st_a !== 2'b01) begin
                    $display("FAIL nonoverlap_refill: state=%b want 01", st_a);
                    bad++;
                end
            end
        end
        total++;
        if (cnt_a !== 8'd1 || st_a !== 2'b01) begin
            $display("FAIL nonoverlap_end: cnt=%0d state=%b, want 1/01", cnt_a, st_a);
            bad++;
        end
    endtask

    task automatic test_en_hold;
        logic zo;
        overlap = 1'b1;
        do_load(4'b1011);
        send(1'b1, 1'b1, zo);
        send(1'b1, 1'b0, zo);
        for (int i = 0; i < 3; i++) begin
            send(1'b0, 1'b1, zo);
            total++;
            if (zo !== 1'b0 || st_a !== 2'b01 || cnt_a !== 8'd0) begin
                $display("FAIL en_hold[%0d]: z=%b state=%b cnt=%0d, want 0/01/0", i, zo, st_a, cnt_a);
                bad++;
            end
        end
        send(1'b1, 1'b1, zo);
        total++;
        if (zo !== 1'b0 || st_a !== 2'b11) begin
            $display("FAIL en_hold_arm: z=%b state=%b, want 0/11", zo, st_a);
            bad++;
        end
        send(1'b1, 1'b1, zo);
        total++;
        if (zo !== 1'b1 || cnt_a !== 8'd1) begin
            $display("FAIL en_hold_match: z=%b cnt=%0d, want 1/1", zo, cnt_a);
            bad++;
        end
    endtask

    task automatic test_saturate;
        logic       zo;
        logic       zb;
        logic [6:0] exp_z;
        exp_z = 7'b0001111;
        overlap = 1'b1;
        do_load(4'b1111);
        for (int i = 0; i < 7; i++) begin
            en = 1'b1; y = 1'b1; load = 1'b0;
            @(negedge clk);
            zo = z_a;
            zb = z_b;
            @(posedge clk);
            #1;
            total++;
            if (zo !== exp_z[6-i] || zb !== exp_z[6-i]) begin
                $display("FAIL sat_z[bit%0d]: a=%b b=%b want %b", i + 1, zo, zb, exp_z[6-i]);
                bad++;
            end
            if (i == 4) begin
                total++;
                if (cnt_b !== 2'd2 || sat_b !== 1'b0) begin
                    $display("FAIL sat_pre: cnt=%0d sat=%b, want 2/0", cnt_b, sat_b);
                    bad++;
                end
            end
            if (i >= 5) begin
                total++;
                if (cnt_b !== 2'd3 || sat_b !== 1'b1) begin
                    $display("FAIL sat_hold[bit%0d]: cnt=%0d sat=%b, want 3/1", i + 1, cnt_b, sat_b);
                    bad++;
                end
            end
        end
        total++;
        if (cnt_a !== 8'd4 || sat_a !== 1'b0) begin
            $display("FAIL sat_wide: cnt=%0d sat=%b, want 4/0", cnt_a, sat_a);
            bad++;
        end
    endtask

    task automatic test_load_priority;
        logic       zo;
        logic [3:0] bits;
        logic [3:0] exp_z;
        overlap = 1'b1;
        do_load(4'b1011);
        send(1'b1, 1'b1, zo);
        send(1'b1, 1'b0, zo);
        send(1'b1, 1'b1, zo);
        en = 1'b1; y = 1'b1; load = 1'b1; pat_in = 4'b0110;
        @(negedge clk);
        zo = z_a;
        @(posedge clk);
        #1;
        load = 1'b0;
        total++;
        if (zo !== 1'b0 || cnt_a !== 8'd0 || st_a !== 2'b01) begin
            $display("FAIL load_prio: z=%b cnt=%0d state=%b, want 0/0/01", zo, cnt_a, st_a);
            bad++;
        end
        bits  = 4'b0110;
        exp_z = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            send(1'b1, bits[3-i], zo);
            total++;
            if (zo !== exp_z[3-i]) begin
                $display("FAIL new_pat_z[bit%0d]: got %b want %b", i + 1, zo, exp_z[3-i]);
                bad++;
            end
        end
        total++;
        if (cnt_a !== 8'd1) begin
            $display("FAIL new_pat_cnt: got %0d want 1", cnt_a);
            bad++;
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_overlap();
        test_async_reset();
        test_nonoverlap();
        test_en_hold();
        test_saturate();
        test_load_priority();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
